fifo_rd_stream: RTL and testbench



---
 rtl/fifo_pkg.sv | 25 ++
 rtl/stream_ring_buf.sv | 108 ++++++++++
 rtl/fifo_rd_stream.sv | 89 ++++++++
 tb/tb_fifo_rd_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared helpers for the FIFO read-side stream logic.
//   - clog2_min1 : index/counter width for a given number of states, never 0.
//   - BUF_DEPTH_MIN / BUF_DEPTH_MAX : legal output buffer depth range.
//   - wrap_last  : last legal ring index for a given depth; ring indices
//                  wrap back to 0 after it, so depths need not be a power of 2.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned BUF_DEPTH_MIN = 2;
  localparam int unsigned BUF_DEPTH_MAX = 8;

  // Bits needed to hold values 0..n-1, with a floor of 1 so a one-entry
  // range still yields a usable vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Highest ring index before wrapping back to zero.
  function automatic int unsigned wrap_last(input int unsigned depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/stream_ring_buf.sv
// ---------------------------------------------------------------------------
// stream_ring_buf
//   BUF_DEPTH x BITS register ring with push/pop, occupancy count and a
//   registered head word.
//
//   Ports:
//     rd_clk     in   clock, rising edge
//     rd_rst     in   synchronous active-high reset (indices/occupancy only)
//     push       in   write push_data at the tail this edge
//     push_data  in   word to write
//     pop        in   drop the head word this edge (caller ensures occ != 0)
//     occ        out  number of stored words, 0..BUF_DEPTH
//     head_valid out  registered (occ != 0)
//     head_data  out  registered copy of the head word
// ---------------------------------------------------------------------------
module stream_ring_buf
  import fifo_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int BUF_DEPTH = 2,
  localparam int OCC_W    = clog2_min1(BUF_DEPTH + 1)
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             push,
  input  logic [BITS-1:0]  push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic             head_valid,
  output logic [BITS-1:0]  head_data
);

  localparam int IDX_W = clog2_min1(BUF_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(wrap_last(BUF_DEPTH));
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(BUF_DEPTH);

  logic [BITS-1:0]      ring_reg [BUF_DEPTH];
  logic [IDX_W-1:0]     wr_idx_reg, wr_idx_next;
  logic [IDX_W-1:0]     rd_idx_reg, rd_idx_next;
  logic [OCC_W-1:0]     occ_reg, occ_next;
  logic                 valid_reg;
  logic [BITS-1:0]      head_reg, head_next;
  logic [BUF_DEPTH-1:0] wr_sel;

  // Explicit wrap compare: depth is not necessarily a power of two.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    wr_idx_next = push ? idx_inc(wr_idx_reg) : wr_idx_reg;
    rd_idx_next = pop  ? idx_inc(rd_idx_reg) : rd_idx_reg;
    occ_next    = occ_reg;
    if (push && !pop) begin
      occ_next = occ_reg + 1'b1;
    end else if (!push && pop) begin
      occ_next = occ_reg - 1'b1;
    end
    // The head after this edge is the entry at the new read index; if that
    // entry is being written this same edge, forward the incoming word.
    head_next = (push && (wr_idx_reg == rd_idx_next)) ? push_data
                                                      : ring_reg[rd_idx_next];
  end

  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = push && (wr_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Storage is not reset; only indices and occupancy define its contents.
  always_ff @(posedge rd_clk) begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (wr_sel[i]) begin
        ring_reg[i] <= push_data;
      end
    end
    head_reg <= head_next;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      occ_reg    <= '0;
      valid_reg  <= 1'b0;
    end else begin
      wr_idx_reg <= wr_idx_next;
      rd_idx_reg <= rd_idx_next;
      occ_reg    <= occ_next;
      valid_reg  <= (occ_next != '0);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      assert (occ_reg <= FULL_OCC);
      assert (!(push && !pop && (occ_reg == FULL_OCC)));
      assert (!(pop && (occ_reg == '0)));
    end
  end

  assign occ        = occ_reg;
  assign head_valid = valid_reg;
  assign head_data  = head_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//   Read-side consumer for the dual-clock FIFO. Issues rd_en, captures rd_data
//   one cycle later into a small ring, and presents the words as a
//   valid/ready stream with registered outputs. Counts delivered beats.
//
//   Ports:
//     rd_clk     in   read-domain clock
//     rd_rst     in   synchronous active-high reset
//     enable     in   0 stops issuing new reads; buffered/in-flight words drain
//     rd_empty   in   FIFO empty flag
//     rd_data    in   FIFO data, valid the cycle after an accepted read
//     rd_en      out  FIFO read request (combinational)
//     out_valid  out  out_data holds a word
//     out_ready  in   downstream accepts out_data this cycle
//     out_data   out  head-of-buffer word
//     beat_cnt   out  delivered beats since reset, wrapping
//     busy       out  words buffered or a read in flight
// ---------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_BITS  = 16
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                enable,
  input  logic                rd_empty,
  input  logic [BITS-1:0]     rd_data,
  output logic                rd_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITS-1:0]     out_data,
  output logic [CNT_BITS-1:0] beat_cnt,
  output logic                busy
);

  localparam int OCC_W = clog2_min1(BUF_DEPTH + 1);
  localparam logic [OCC_W:0] DEPTH_EXT = (OCC_W + 1)'(BUF_DEPTH);

  logic [OCC_W-1:0]    occ;
  logic [OCC_W:0]      pending;
  logic                pop;
  logic                inflight_reg;
  logic [CNT_BITS-1:0] beat_cnt_reg;

  assign pop = out_valid && out_ready;

  // Extra bit so occ + inflight cannot wrap at full occupancy.
  assign pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_reg};

  // A slot is guaranteed either by free space or by the pop on this edge.
  // Together these keep occ + inflight <= BUF_DEPTH at every edge.
  assign rd_en = !rd_rst && enable && !rd_empty && ((pending < DEPTH_EXT) || pop);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_reg <= 1'b0;
      beat_cnt_reg <= '0;
    end else begin
      inflight_reg <= rd_en;
      if (pop) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end
    end
  end

  // The in-flight word is written unconditionally on the following edge;
  // rd_rst on that edge resets the ring pointers, discarding it.
  stream_ring_buf #(
    .BITS      (BITS),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_ring (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .push       (inflight_reg),
    .push_data  (rd_data),
    .pop        (pop),
    .occ        (occ),
    .head_valid (out_valid),
    .head_data  (out_data)
  );

  assign beat_cnt = beat_cnt_reg;
  assign busy     = !rd_rst && ((occ != '0) || inflight_reg);

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  localparam int BITS      = 32;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_BITS  = 4;
  localparam int CNT_MOD   = 2 ** CNT_BITS;

  logic                rd_clk = 1'b0;
  logic                rd_rst = 1'b1;
  logic                enable = 1'b0;
  logic                rd_empty = 1'b1;
  logic [BITS-1:0]     rd_data = '0;
  logic                rd_en;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [BITS-1:0]     out_data;
  logic [CNT_BITS-1:0] beat_cnt;
  logic                busy;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(
    .BITS      (BITS),
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_BITS  (CNT_BITS)
  ) dut (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .enable    (enable),
    .rd_empty  (rd_empty),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .beat_cnt  (beat_cnt),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int delivered = 0;
  int beat_model = 0;
  logic hold_empty = 1'b0;

  logic [BITS-1:0] fifo_q[$];
  logic [BITS-1:0] exp_q[$];

  logic                s_rd_en, s_valid, s_busy;
  logic [BITS-1:0]     s_data;
  logic [CNT_BITS-1:0] s_beat;

  // Hand-computed profile for the first streaming burst (4 words, ready=1).
  logic       t1_en_exp [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       t1_v_exp  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       t1_en_h   [7];
  logic       t1_v_h    [7];
  logic [BITS-1:0] t1_d_h [7];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [BITS-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic fifo_reset();
    fifo_q.delete();
    exp_q.delete();
    issued     = 0;
    delivered  = 0;
    beat_model = 0;
  endtask

  // One clock: present rd_empty, sample outputs at the falling edge, score
  // any handshake, then model the FIFO returning data after the rising edge.
  task automatic step();
    logic [BITS-1:0] w;
    rd_empty = hold_empty || (fifo_q.size() == 0);
    @(negedge rd_clk);
    s_rd_en = rd_en;
    s_valid = out_valid;
    s_data  = out_data;
    s_busy  = busy;
    s_beat  = beat_cnt;
    chk("rd_en_while_empty", {63'd0, (rd_en && rd_empty)}, 64'd0);
    if (!rd_rst) begin
      chk("outstanding_le_depth", {63'd0, ((issued - delivered) <= BUF_DEPTH)}, 64'd1);
      chk("beat_cnt_track", 64'(s_beat), 64'(beat_model % CNT_MOD));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(exp_q.size()), 64'd1);
        end else begin
          w = exp_q.pop_front();
          chk("order", 64'(out_data), 64'(w));
        end
        delivered++;
        beat_model++;
        $display("beat %0d data=%08h beat_cnt=%0d", delivered, out_data, beat_cnt);
      end
    end
    @(posedge rd_clk);
    #1;
    if (s_rd_en && !rd_rst) begin
      issued++;
      if (fifo_q.size() != 0) begin
        rd_data = fifo_q.pop_front();
      end
    end
  endtask

  initial begin
    int reads;
    int guard;
    int n;
    int start;

    // Reset with data already waiting: nothing may be read.
    rd_rst    = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    repeat (3) begin
      step();
      chk("rst_rd_en", 64'(s_rd_en), 64'd0);
    end
    chk("rst_out_valid", 64'(s_valid), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_beat_cnt", 64'(s_beat), 64'd0);

    // Full-rate burst of A0..A3.
    rd_rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      t1_en_h[k] = s_rd_en;
      t1_v_h[k]  = s_valid;
      t1_d_h[k]  = s_data;
    end
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t1_rd_en_%0d", k), 64'(t1_en_h[k]), 64'(t1_en_exp[k]));
      chk($sformatf("t1_valid_%0d", k), 64'(t1_v_h[k]), 64'(t1_v_exp[k]));
    end
    for (int k = 2; k < 6; k++) begin
      chk($sformatf("t1_data_%0d", k), 64'(t1_d_h[k]), 64'(32'hA0 + 32'(k - 2)));
    end
    chk("t1_beat_cnt", 64'(s_beat), 64'd4);
    chk("t1_busy_idle", 64'(s_busy), 64'd0);

    // Backpressure: only BUF_DEPTH reads, head held stable.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'hB0 + 32'(i));
    reads = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_rd_en) reads++;
      if (k == 3) chk("t2_hold_data_mid", 64'(s_data), 64'h0B0);
    end
    chk("t2_reads", 64'(reads), 64'd2);
    chk("t2_valid", 64'(s_valid), 64'd1);
    chk("t2_hold_data", 64'(s_data), 64'h0B0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("t2_no_gap_%0d", k), 64'(s_valid), 64'd1);
      if (k == 7) chk("t2_last_data", 64'(s_data), 64'h0B7);
    end
    step();
    chk("t2_drained", 64'(s_valid), 64'd0);

    // Random backpressure, refill and empty-flag toggling.
    n = 0;
    guard = 0;
    start = delivered;
    while (((delivered - start) < 1000) && (guard < 20000)) begin
      if ((n < 1000) && ($urandom_range(1) == 1)) begin
        push_word(32'h3000_0000 + 32'(n));
        n++;
      end
      out_ready  = 1'($urandom_range(1));
      hold_empty = ($urandom_range(7) == 0);
      step();
      guard++;
    end
    chk("t3_all_delivered", 64'(delivered - start), 64'd1000);
    hold_empty = 1'b0;
    out_ready  = 1'b1;
    step();
    chk("t3_idle", 64'(s_busy), 64'd0);

    // enable drops right after an accepted read.
    for (int i = 0; i < 4; i++) push_word(32'hC0 + 32'(i));
    step();
    chk("t4_first_rd", 64'(s_rd_en), 64'd1);
    enable = 1'b0;
    step();
    chk("t4_rd_en_off", 64'(s_rd_en), 64'd0);
    chk("t4_busy_inflight", 64'(s_busy), 64'd1);
    step();
    chk("t4_inflight_valid", 64'(s_valid), 64'd1);
    chk("t4_inflight_data", 64'(s_data), 64'h0C0);
    step();
    chk("t4_rd_en_still_off", 64'(s_rd_en), 64'd0);
    chk("t4_valid_off", 64'(s_valid), 64'd0);
    chk("t4_busy_off", 64'(s_busy), 64'd0);
    enable = 1'b1;
    step();
    chk("t4_resume_rd", 64'(s_rd_en), 64'd1);
    step();
    step();
    chk("t4_resume_valid", 64'(s_valid), 64'd1);
    chk("t4_resume_data", 64'(s_data), 64'h0C1);
    repeat (3) step();
    chk("t4_busy_end", 64'(s_busy), 64'd0);

    // Reset mid-transfer with one word buffered and one in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hE0 + 32'(i));
    step();
    chk("t5_rd0", 64'(s_rd_en), 64'd1);
    step();
    chk("t5_rd1", 64'(s_rd_en), 64'd1);
    rd_rst = 1'b1;
    step();
    chk("t5_rd_en_in_reset", 64'(s_rd_en), 64'd0);
    rd_rst = 1'b0;
    fifo_reset();
    step();
    chk("t5_valid", 64'(s_valid), 64'd0);
    chk("t5_busy", 64'(s_busy), 64'd0);
    chk("t5_beat_cnt", 64'(s_beat), 64'd0);
    out_ready = 1'b1;
    push_word(32'hF0);
    push_word(32'hF1);
    step();
    chk("t5_restart_rd", 64'(s_rd_en), 64'd1);
    step();
    step();
    chk("t5_first_valid", 64'(s_valid), 64'd1);
    chk("t5_first_word", 64'(s_data), 64'h0F0);
    step();
    step();
    chk("t5_busy_end", 64'(s_busy), 64'd0);

    // beat_cnt wrap with a 4-bit counter: 18 pops leave 2.
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
    fifo_reset();
    for (int i = 0; i < 18; i++) push_word(32'h60 + 32'(i));
    guard = 0;
    while ((delivered < 18) && (guard < 100)) begin
      step();
      guard++;
    end
    chk("t6_pops", 64'(delivered), 64'd18);
    step();
    chk("t6_beat_wrap", 64'(s_beat), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
